// File: rtl/crc_pkg.sv
// Shared CRC parameters, derived widths and checker state encoding.
// Used by both the CRC generator and crc_checker.
package crc_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int POLY_W_DEF = 4;
  localparam int ERRCNT_W   = 8;

  function automatic int crc_w(input int poly_w);
    return poly_w - 1;
  endfunction

  function automatic int cw_w(input int data_w, input int poly_w);
    return data_w + poly_w - 1;
  endfunction

  localparam int CRC_W_DEF = crc_w(POLY_W_DEF);
  localparam int CW_W_DEF  = cw_w(DATA_W_DEF, POLY_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

endpackage

// File: rtl/crc_div_step.sv
// One combinational mod-2 long-division step on the codeword register.
// Divisor MSB is aligned with the register MSB before the XOR.
module crc_div_step
  import crc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int POLY_W = POLY_W_DEF,
  localparam int CW_W  = cw_w(DATA_W, POLY_W)
) (
  input  logic [CW_W-1:0]   i_sr,
  input  logic [POLY_W-1:0] i_dv,
  output logic [CW_W-1:0]   o_sr_next
);

  logic [CW_W-1:0] w_dv_al;
  logic [CW_W-1:0] w_xor;

  assign w_dv_al = {i_dv, {(DATA_W-1){1'b0}}};
  assign w_xor   = i_sr[CW_W-1] ? (i_sr ^ w_dv_al) : i_sr;
  assign o_sr_next = w_xor << 1;

endmodule

// File: rtl/crc_checker.sv
// Bit-serial CRC checker: divides a received codeword, flags nonzero remainder.
// Optional macro CRC_CHK_CNT_EN adds a saturating error counter output.
module crc_checker
  import crc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int POLY_W = POLY_W_DEF,
  localparam int CRC_W = crc_w(POLY_W),
  localparam int CW_W  = cw_w(DATA_W, POLY_W)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_e,
  input  logic [CW_W-1:0]   i_codeword,
  input  logic [POLY_W-1:0] i_divisor,
  output logic              o_busy,
  output logic              o_valid,
  output logic [CRC_W-1:0]  o_remainder,
  output logic              o_err,
  output logic              o_div_fault
`ifdef CRC_CHK_CNT_EN
  ,
  output logic [ERRCNT_W-1:0] o_err_count
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_DIV  = DIV;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CW_W-1:0]   r_sr;
  logic [POLY_W-1:0] r_dv;
  logic              r_busy;
  logic              r_valid;
  logic [CRC_W-1:0]  r_rem;
  logic              r_err;
  logic              r_fault;

  logic [CW_W-1:0]   w_sr_next;
  logic [CRC_W-1:0]  w_rem;
  logic              w_fault;
  logic              w_err;
  logic              w_last;

  crc_div_step #(
    .DATA_W (DATA_W),
    .POLY_W (POLY_W)
  ) u_step (
    .i_sr      (r_sr),
    .i_dv      (r_dv),
    .o_sr_next (w_sr_next)
  );

  // A divisor without its top term is not a valid generator.
  assign w_fault = ~r_dv[POLY_W-1];
  assign w_rem   = w_fault ? '0 : r_sr[CW_W-1 -: CRC_W];
  assign w_err   = w_fault | (|w_rem);
  assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_dv    <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_rem   <= '0;
      r_err   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (i_e) begin
            r_sr   <= i_codeword;
            r_dv   <= i_divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_state <= i_divisor[POLY_W-1] ?
                       ST_DIV : ST_DONE;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_DIV: begin
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_valid <= 1'b1;
          r_rem   <= w_rem;
          r_err   <= w_err;
          r_fault <= w_fault;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef CRC_CHK_CNT_EN
  logic [ERRCNT_W-1:0] r_errcnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_errcnt <= '0;
    end else if (r_state == ST_DONE && w_err &&
                 r_errcnt != '1) begin
      r_errcnt <= r_errcnt + ERRCNT_W'(1);
    end
  end

  assign o_err_count = r_errcnt;
`endif

  assign o_busy      = r_busy;
  assign o_valid     = r_valid;
  assign o_remainder = r_rem;
  assign o_err       = r_err;
  assign o_div_fault = r_fault;

endmodule

// File: tb/tb_crc_checker.sv
// Randomised self-checking bench for crc_checker against a polynomial model.
// Covers CRC_CHK_CNT_EN counter checks when that macro is defined.
module tb_crc_checker;

  localparam int DATA_W = 14;
  localparam int POLY_W = 4;
  localparam int CRC_W  = 3;
  localparam int CW_W   = 17;
  localparam int LAT    = 16;
  localparam int FLAT   = 2;

  logic              clk;
  logic              i_reset;
  logic              i_e;
  logic [CW_W-1:0]   i_codeword;
  logic [POLY_W-1:0] i_divisor;
  logic              o_busy;
  logic              o_valid;
  logic [CRC_W-1:0]  o_remainder;
  logic              o_err;
  logic              o_div_fault;
`ifdef CRC_CHK_CNT_EN
  logic [7:0]        o_err_count;
`endif

  int checks = 0;
  int errors = 0;
  int m_errcnt = 0;

  crc_checker #(
    .DATA_W (DATA_W),
    .POLY_W (POLY_W)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_e         (i_e),
    .i_codeword  (i_codeword),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_remainder (o_remainder),
    .o_err       (o_err),
    .o_div_fault (o_div_fault)
`ifdef CRC_CHK_CNT_EN
    ,
    .o_err_count (o_err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Textbook polynomial remainder: cancel each set term from the top down.
  function automatic logic [CRC_W-1:0] ref_rem(
    input logic [CW_W-1:0] cw, input logic [POLY_W-1:0] dv);
    logic [CW_W-1:0] x;
    x = cw;
    for (int i = CW_W - 1; i >= CRC_W; i--)
      if (x[i]) x = x ^ (CW_W'(dv) << (i - CRC_W));
    return x[CRC_W-1:0];
  endfunction

  task automatic run_op(input logic [CW_W-1:0] cw,
                        input logic [POLY_W-1:0] dv,
                        output int lat,
                        output logic [CRC_W-1:0] rem,
                        output logic err,
                        output logic flt);
    @(negedge clk);
    i_e = 1'b1;
    i_codeword = cw;
    i_divisor = dv;
    @(negedge clk);
    i_e = 1'b0;
    i_codeword = CW_W'($urandom);
    i_divisor = POLY_W'($urandom);
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rem = o_remainder;
    err = o_err;
    flt = o_div_fault;
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    i_e = 1'b0;
    i_codeword = '0;
    i_divisor = '0;
    #1;
    checks++;
    if ({o_busy, o_valid, o_err, o_div_fault, o_remainder} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0",
               {o_busy, o_valid, o_err, o_div_fault, o_remainder});
    end
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    i_e = 1'b1;
    @(negedge clk);
    i_e = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_accept busy=%b want 1", o_busy);
    end
    repeat (LAT + 2) @(negedge clk);
`ifdef CRC_CHK_CNT_EN
    checks++;
    if (o_err_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_errcnt got %0d want 1", o_err_count);
    end
    m_errcnt = 1;
`endif
  endtask

  task automatic test_directed;
    logic [CW_W-1:0] cws [3];
    logic [CRC_W-1:0] exp_rem [3];
    int lat;
    logic [CRC_W-1:0] rem;
    logic err, flt;
    cws[0] = 17'b11010011101100_100; exp_rem[0] = 3'b000;
    cws[1] = 17'b11000110000110_010; exp_rem[1] = 3'b000;
    cws[2] = 17'b01010011101100_100; exp_rem[2] = 3'b100;
    for (int i = 0; i < 3; i++) begin
      run_op(cws[i], 4'b1011, lat, rem, err, flt);
      if (exp_rem[i] != 0 && m_errcnt < 255) m_errcnt++;
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT);
      end
      checks++;
      if ({rem, err, flt} !== {exp_rem[i], exp_rem[i] != 0, 1'b0}) begin
        errors++;
        $display("FAIL dir%0d_result got rem=%b err=%b flt=%b want rem=%b",
                 i, rem, err, flt, exp_rem[i]);
      end
`ifdef CRC_CHK_CNT_EN
      checks++;
      if (o_err_count !== 8'(m_errcnt)) begin
        errors++;
        $display("FAIL dir%0d_errcnt got %0d want %0d",
                 i, o_err_count, m_errcnt);
      end
`endif
    end
  endtask

  task automatic test_divfault;
    int lat;
    logic [CRC_W-1:0] rem;
    logic err, flt;
    run_op(17'b11010011101100_111, 4'b0011, lat, rem, err, flt);
    if (m_errcnt < 255) m_errcnt++;
    checks++;
    if (lat !== FLAT) begin
      errors++;
      $display("FAIL divfault_latency got %0d want %0d", lat, FLAT);
    end
    checks++;
    if ({rem, err, flt} !== {3'b000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL divfault_result got rem=%b err=%b flt=%b want 000 1 1",
               rem, err, flt);
    end
    @(negedge clk);
    checks++;
    if ({o_busy, o_valid} !== 2'b00) begin
      errors++;
      $display("FAIL divfault_idle got busy/valid=%b want 00",
               {o_busy, o_valid});
    end
  endtask

  task automatic test_random;
    logic [DATA_W-1:0] d;
    logic [POLY_W-1:0] dv;
    logic [CW_W-1:0] cw;
    logic [CRC_W-1:0] er, rem;
    logic ee, ef, err, flt;
    int el, lat;
    for (int n = 0; n < 24; n++) begin
      d = DATA_W'($urandom);
      dv = POLY_W'($urandom);
      if ($urandom_range(0, 3) != 0) dv[POLY_W-1] = 1'b1;
      cw = {d, ref_rem({d, 3'b000}, dv)};
      if ($urandom_range(0, 1) == 1)
        cw[$urandom_range(0, CW_W - 1)] ^= 1'b1;
      ef = ~dv[POLY_W-1];
      er = ef ? 3'b000 : ref_rem(cw, dv);
      ee = ef | (er != 0);
      el = ef ? FLAT : LAT;
      run_op(cw, dv, lat, rem, err, flt);
      if (ee && m_errcnt < 255) m_errcnt++;
      checks++;
      if (lat !== el) begin
        errors++;
        $display("FAIL rand%0d_latency got %0d want %0d", n, lat, el);
      end
      checks++;
      if ({rem, err, flt} !== {er, ee, ef}) begin
        errors++;
        $display("FAIL rand%0d cw=%b dv=%b got %b %b %b want %b %b %b",
                 n, cw, dv, rem, err, flt, er, ee, ef);
      end
`ifdef CRC_CHK_CNT_EN
      checks++;
      if (o_err_count !== 8'(m_errcnt)) begin
        errors++;
        $display("FAIL rand%0d_errcnt got %0d want %0d",
                 n, o_err_count, m_errcnt);
      end
`endif
    end
  endtask

  task automatic test_hold_e;
    int nv;
    logic [CRC_W-1:0] rem;
    @(negedge clk);
    i_e = 1'b1;
    i_codeword = 17'b01010011101100_100;
    i_divisor = 4'b1011;
    repeat (5) @(negedge clk);
    i_e = 1'b0;
    nv = 0;
    rem = '0;
    for (int i = 0; i < 40; i++) begin
      if (o_valid) begin
        nv++;
        rem = o_remainder;
      end
      @(negedge clk);
    end
    if (m_errcnt < 255) m_errcnt++;
    checks++;
    if (nv !== 1) begin
      errors++;
      $display("FAIL hold_e_pulses got %0d want 1", nv);
    end
    checks++;
    if (rem !== 3'b100) begin
      errors++;
      $display("FAIL hold_e_rem got %b want 100", rem);
    end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] d1, d2;
    logic [POLY_W-1:0] p1, p2;
    logic [CW_W-1:0] c1, c2;
    int lat;
    d1 = DATA_W'($urandom);
    d2 = DATA_W'($urandom);
    p1 = POLY_W'($urandom) | 4'b1000;
    p2 = POLY_W'($urandom) | 4'b1000;
    c1 = {d1, ref_rem({d1, 3'b000}, p1)};
    c2 = {d2, 3'b101};
    @(negedge clk);
    i_e = 1'b1;
    i_codeword = c1;
    i_divisor = p1;
    @(negedge clk);
    i_codeword = c2;
    i_divisor = p2;
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== LAT || o_remainder !== 3'b000 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d rem=%b err=%b want %0d 000 0",
               lat, o_remainder, o_err, LAT);
    end
    @(negedge clk);
    i_e = 1'b0;
    checks++;
    if ({o_busy, o_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_restart got busy/valid=%b want 10",
               {o_busy, o_valid});
    end
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (ref_rem(c2, p2) != 0 && m_errcnt < 255) m_errcnt++;
    checks++;
    if (lat !== LAT || o_remainder !== ref_rem(c2, p2) ||
        o_err !== (ref_rem(c2, p2) != 0)) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d rem=%b want %0d %b",
               lat, o_remainder, LAT, ref_rem(c2, p2));
    end
  endtask

  task automatic test_reset_mid;
    int lat, nv;
    logic [CRC_W-1:0] rem;
    logic err, flt;
    run_op(17'b01010011101100_100, 4'b1011, lat, rem, err, flt);
    @(negedge clk);
    i_e = 1'b1;
    i_codeword = 17'b11010011101100_100;
    i_divisor = 4'b1011;
    @(negedge clk);
    i_e = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({o_busy, o_err} !== 2'b11) begin
      errors++;
      $display("FAIL rmid_pre got busy/err=%b want 11", {o_busy, o_err});
    end
    #2 i_reset = 1'b1;
    #1;
    m_errcnt = 0;
    checks++;
    if ({o_busy, o_valid, o_err, o_div_fault, o_remainder} !== '0) begin
      errors++;
      $display("FAIL rmid_async got %b want 0",
               {o_busy, o_valid, o_err, o_div_fault, o_remainder});
    end
`ifdef CRC_CHK_CNT_EN
    checks++;
    if (o_err_count !== 8'd0) begin
      errors++;
      $display("FAIL rmid_errcnt got %0d want 0", o_err_count);
    end
`endif
    @(negedge clk);
    i_reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_valid) nv++;
    end
    checks++;
    if (nv !== 0) begin
      errors++;
      $display("FAIL rmid_no_valid got %0d pulses want 0", nv);
    end
    run_op(17'b11000110000110_010, 4'b1011, lat, rem, err, flt);
    checks++;
    if (lat !== LAT || {rem, err, flt} !== 5'b000_0_0) begin
      errors++;
      $display("FAIL rmid_fresh got lat=%0d rem=%b err=%b flt=%b",
               lat, rem, err, flt);
    end
  endtask

`ifdef CRC_CHK_CNT_EN
  task automatic test_errcnt_sat;
    int lat;
    logic [CRC_W-1:0] rem;
    logic err, flt;
    for (int i = 0; i < 258; i++) begin
      run_op(CW_W'($urandom), 4'b0101, lat, rem, err, flt);
      if (m_errcnt < 255) m_errcnt++;
    end
    checks++;
    if (o_err_count !== 8'(m_errcnt)) begin
      errors++;
      $display("FAIL errcnt_sat got %0d want %0d", o_err_count, m_errcnt);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_divfault;
    test_random;
    test_hold_e;
    test_back_to_back;
    test_reset_mid;
`ifdef CRC_CHK_CNT_EN
    test_errcnt_sat;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
